// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared seven-segment display constants
// Contents:
//   SEG_OFF    : all segments dark (active-low), decimal point off
//   AN_OFF     : all digit anodes disabled (active-low)
//   HEX7_TABLE : hex nibble -> active-low {g,f,e,d,c,b,a}, index = nibble value
package seg7_scan_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Packed so that HEX7_TABLE[n] is the pattern for nibble n; the first
  // element of the concatenation lands in the highest index (F).
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to seven-segment decoder
// Ports:
//   nib   : 4-bit hex value
//   seg_n : active-low segments {g,f,e,d,c,b,a}
module hex7seg
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = HEX7_TABLE[nib];

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 8-digit hex seven-segment scanner
// Parameters:
//   DIV  : clock cycles per digit slot (2 .. 2^20)
//   DEAD : cycles at the start of each slot with all anodes off (0 .. DIV-1)
// Ports:
//   CLK     : system clock
//   RST_N   : asynchronous active-low reset
//   Vdata   : 32-bit word to display, nibble i -> digit i (digit 0 rightmost)
//   SEL_LED : one-hot source indicator, mirrored on LED after one register
//   BLANK   : leading-zero blanking enable
//   FREEZE  : hold the displayed snapshot across frame boundaries
//   SEG     : active-low segments, SEG[7] decimal point (always off)
//   AN      : active-low digit enables, AN[i] selects digit i
//   LED     : registered copy of SEL_LED
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int DIV  = 50000,
  parameter int DEAD = 500
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] Vdata,
  input  logic [4:0]  SEL_LED,
  input  logic        BLANK,
  input  logic        FREEZE,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic [4:0]  LED
);

  localparam int          CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [31:0] DEAD_U = DEAD;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [4:0]    led_q, led_d;

  logic          tick;
  logic          in_dead;
  logic          blank_dig;
  logic [3:0]    nib;
  logic [6:0]    dec_n;
  logic [7:0]    zero_from;

  hex7seg u_hex7seg (
    .nib   (nib),
    .seg_n (dec_n)
  );

  // zero_from[i] is set when snapshot nibbles i..7 are all zero, i.e. digit i
  // is a leading zero.
  always_comb begin
    zero_from    = '0;
    zero_from[7] = (snap_q[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (snap_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    tick      = (cnt_q == CW'(DIV - 1));
    in_dead   = ({{(32-CW){1'b0}}, cnt_q} < DEAD_U);
    nib       = snap_q[{idx_q, 2'b00} +: 4];
    blank_dig = BLANK && (idx_q != 3'd0) && zero_from[idx_q];

    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    idx_d  = tick ? idx_q + 3'd1 : idx_q;
    // Only reload at the end of slot 7 so a frame never mixes two words.
    snap_d = (tick && (idx_q == 3'd7) && !FREEZE) ? Vdata : snap_q;
    led_d  = SEL_LED;

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!in_dead && !blank_dig) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = {1'b1, dec_n};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      snap_q <= 32'h0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      led_q  <= 5'd0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      led_q  <= led_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign LED = led_q;

endmodule
